sensor_word_arbiter: RTL and testbench

Collects decoded BMC words from `NB_SENSORS` parallel `bmc_decoder` instances and serialises them onto one tagged output stream with valid/ready flow control. Each channel has a one-word holding register; a round-robin arbiter drains them into a single output register. The block also gates each decoder's `enabled` input and flags per-channel overflow. It sits between the photodiode decoder bank and the frame assembler / SPI readout.

---
 rtl/vive_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/sensor_word_arbiter.sv | 131 +++++++++++++
 tb/tb_sensor_word_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vive_pkg.sv
// -----------------------------------------------------------------------------
// vive_pkg
// Shared constants for the photodiode decoder bank and its readout path.
//   DEFAULT_NB_SENSORS     number of bmc_decoder channels
//   DEFAULT_BIT_CONSIDERED decoded word width per channel
//   DEFAULT_TS_WIDTH       timestamp width
//   DEFAULT_ID_WIDTH       sensor id width, clog2 of the channel count
// Flattened per-channel buses put channel i at [i*width +: width]; lane_lsb()
// returns that base index so every user slices the bus the same way.
// -----------------------------------------------------------------------------
package vive_pkg;

    localparam int DEFAULT_NB_SENSORS     = 4;
    localparam int DEFAULT_BIT_CONSIDERED = 17;
    localparam int DEFAULT_TS_WIDTH       = 24;
    localparam int DEFAULT_ID_WIDTH       = $clog2(DEFAULT_NB_SENSORS);

    function automatic int lane_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter with a registered priority pointer.
// The search starts at the channel after the last granted one; after reset
// channel 0 has the highest priority.
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   req      in   N   request vector
//   advance  in   1   the current grant was taken; move the pointer past it
//   grant    out  N   one-hot grant (all zero when nothing requests)
//   grant_id out  IDW binary index of the granted channel
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           advance,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    logic [IDW-1:0] ptr;

    always_comb begin : search
        int  idx;
        logic found;
        // NOTE: combinational logic uses blocking '=' so later statements see
        // the updated value within the same evaluation; registers use '<='.
        // NOTE: every output gets a default first, otherwise paths that do not
        // assign it would infer a latch.
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && (|req)) begin
            ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_word_arbiter.sv
// -----------------------------------------------------------------------------
// sensor_word_arbiter
// Collects words from NB_SENSORS bmc_decoder channels into one-word holding
// registers and drains them round-robin onto a single valid/ready stream
// tagged with the source channel. Also gates each decoder's enable and keeps
// sticky per-channel overflow flags for words lost to a full holding register.
//   clk_96MHz           in   system clock
//   reset               in   synchronous, active-high reset
//   enabled             in   global enable
//   channel_mask        in   NB_SENSORS       1 = channel in use
//   decoder_enable      out  NB_SENSORS       registered enabled & channel_mask
//   decoded_data        in   NB*bit_considered flattened decoder words
//   data_availible      in   NB_SENSORS       one-cycle word strobe per channel
//   timestamp_last_data in   NB*TS_WIDTH      flattened word timestamps
//   out_valid/out_ready      output handshake
//   out_data, out_timestamp, out_sensor_id    output word, stable while stalled
//   overflow            out  NB_SENSORS       sticky word-lost flags
//   overflow_clear      in   1                clears all overflow flags
// -----------------------------------------------------------------------------
module sensor_word_arbiter
    import vive_pkg::*;
#(
    parameter int NB_SENSORS     = DEFAULT_NB_SENSORS,
    parameter int bit_considered = DEFAULT_BIT_CONSIDERED,
    parameter int TS_WIDTH       = DEFAULT_TS_WIDTH,
    parameter int ID_WIDTH       = DEFAULT_ID_WIDTH
) (
    input  logic                               clk_96MHz,
    input  logic                               reset,
    input  logic                               enabled,
    input  logic [NB_SENSORS-1:0]              channel_mask,
    output logic [NB_SENSORS-1:0]              decoder_enable,
    input  logic [NB_SENSORS*bit_considered-1:0] decoded_data,
    input  logic [NB_SENSORS-1:0]              data_availible,
    input  logic [NB_SENSORS*TS_WIDTH-1:0]     timestamp_last_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [bit_considered-1:0]          out_data,
    output logic [TS_WIDTH-1:0]                out_timestamp,
    output logic [ID_WIDTH-1:0]                out_sensor_id,
    output logic [NB_SENSORS-1:0]              overflow,
    input  logic                               overflow_clear
);

    logic [NB_SENSORS-1:0]     pending;
    logic [bit_considered-1:0] hold_data [NB_SENSORS];
    logic [TS_WIDTH-1:0]       hold_ts   [NB_SENSORS];

    logic [NB_SENSORS-1:0] live_en;
    logic [NB_SENSORS-1:0] req;
    logic [NB_SENSORS-1:0] pulse;
    logic [NB_SENSORS-1:0] grant;
    logic [NB_SENSORS-1:0] pop;
    logic [NB_SENSORS-1:0] ovf_event;
    logic [NB_SENSORS-1:0] capture;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  load;

    // Requests use the live enable so a word on a channel being masked off
    // is never granted in the cycle its pending bit is being cleared.
    assign live_en   = {NB_SENSORS{enabled}} & channel_mask;
    assign req       = pending & live_en;
    assign pulse     = data_availible & decoder_enable;
    assign load      = (!out_valid || out_ready) && (|req);
    assign pop       = load ? grant : '0;
    // A full holding register only accepts a new word if it is being popped
    // in the same cycle; otherwise the newest word is the one dropped.
    assign capture   = pulse & (~pending | pop);
    assign ovf_event = pulse & pending & ~pop & live_en;

    rr_arbiter #(
        .N   (NB_SENSORS),
        .IDW (ID_WIDTH)
    ) u_rr_arbiter (
        .clk      (clk_96MHz),
        .reset    (reset),
        .req      (req),
        .advance  (load),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            decoder_enable <= '0;
            overflow       <= '0;
            pending        <= '0;
        end else begin
            decoder_enable <= live_en;
            // Clear is applied first so a same-cycle overflow event still sets.
            overflow       <= (overflow_clear ? '0 : overflow) | ovf_event;
            for (int i = 0; i < NB_SENSORS; i++) begin
                if (!live_en[i]) begin
                    pending[i] <= 1'b0;
                end else if (pulse[i]) begin
                    pending[i] <= 1'b1;
                end else if (pop[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // NOTE: the holding payload is not reset; pending[] alone says whether a
    // slot holds a live word, so clearing pending discards it.
    always_ff @(posedge clk_96MHz) begin
        for (int i = 0; i < NB_SENSORS; i++) begin
            if (capture[i]) begin
                hold_data[i] <= decoded_data[lane_lsb(i, bit_considered) +: bit_considered];
                hold_ts[i]   <= timestamp_last_data[lane_lsb(i, TS_WIDTH) +: TS_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_timestamp <= '0;
            out_sensor_id <= '0;
        end else if (load) begin
            out_valid     <= 1'b1;
            out_data      <= hold_data[grant_id];
            out_timestamp <= hold_ts[grant_id];
            out_sensor_id <= grant_id;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sensor_word_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sensor_word_arbiter
// Scoreboard bench: every word expected on the output is queued when its
// strobe is driven and compared, in order, when the output handshake fires.
// -----------------------------------------------------------------------------
module tb_sensor_word_arbiter;

    localparam int N = 4;
    localparam int W = 17;
    localparam int T = 24;
    localparam int I = 2;

    logic           clk_96MHz = 1'b0;
    logic           reset = 1'b1;
    logic           enabled = 1'b0;
    logic [N-1:0]   channel_mask = '0;
    logic [N-1:0]   decoder_enable;
    logic [N*W-1:0] decoded_data = '0;
    logic [N-1:0]   data_availible = '0;
    logic [N*T-1:0] timestamp_last_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_data;
    logic [T-1:0]   out_timestamp;
    logic [I-1:0]   out_sensor_id;
    logic [N-1:0]   overflow;
    logic           overflow_clear = 1'b0;

    typedef struct packed {
        logic [I-1:0] id;
        logic [W-1:0] data;
        logic [T-1:0] ts;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    sensor_word_arbiter #(
        .NB_SENSORS     (N),
        .bit_considered (W),
        .TS_WIDTH       (T),
        .ID_WIDTH       (I)
    ) dut (
        .clk_96MHz           (clk_96MHz),
        .reset               (reset),
        .enabled             (enabled),
        .channel_mask        (channel_mask),
        .decoder_enable      (decoder_enable),
        .decoded_data        (decoded_data),
        .data_availible      (data_availible),
        .timestamp_last_data (timestamp_last_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_timestamp       (out_timestamp),
        .out_sensor_id       (out_sensor_id),
        .overflow            (overflow),
        .overflow_clear      (overflow_clear)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: compare each accepted word against the scoreboard head.
    always @(negedge clk_96MHz) begin
        if (!reset && out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_id",   32'(out_sensor_id), 32'(e.id));
                check("out_data", 32'(out_data),      32'(e.data));
                check("out_ts",   32'(out_timestamp), 32'(e.ts));
            end
        end
    end

    task automatic tick();
        @(posedge clk_96MHz);
        #1;
    endtask

    task automatic set_word(input int ch, input logic [W-1:0] d, input logic [T-1:0] t,
                            input bit expect_out);
        exp_t e;
        data_availible[ch]               = 1'b1;
        decoded_data[ch*W +: W]          = d;
        timestamp_last_data[ch*T +: T]   = t;
        if (expect_out) begin
            e.id   = I'(ch);
            e.data = d;
            e.ts   = t;
            sb.push_back(e);
        end
    endtask

    task automatic clear_pulses();
        data_availible = '0;
    endtask

    task automatic do_reset();
        clear_pulses();
        out_ready      = 1'b0;
        overflow_clear = 1'b0;
        reset          = 1'b1;
        tick();
        tick();
        reset          = 1'b0;
    endtask

    task automatic setup();
        enabled      = 1'b1;
        channel_mask = 4'b1111;
        tick();
        tick();
    endtask

    task automatic wait_drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 40 && (sb.size() != 0 || out_valid); k++) tick();
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_idle"},     32'(out_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid",   32'(out_valid),      32'd0);
        check("rst_data",    32'(out_data),       32'd0);
        check("rst_ts",      32'(out_timestamp),  32'd0);
        check("rst_id",      32'(out_sensor_id),  32'd0);
        check("rst_ovf",     32'(overflow),       32'd0);
        check("rst_dec_en",  32'(decoder_enable), 32'd0);

        // Single word: two-cycle latency, one-cycle handshake
        setup();
        check("dec_en_on", 32'(decoder_enable), 32'hF);
        out_ready = 1'b1;
        set_word(2, 17'h1A5A5, 24'h000100, 1'b1);
        tick();
        clear_pulses();
        check("lat_edge_n",  32'(out_valid), 32'd0);
        tick();
        check("lat_edge_n1", 32'(out_valid), 32'd1);
        check("single_id",   32'(out_sensor_id), 32'd2);
        tick();
        check("single_drop", 32'(out_valid), 32'd0);
        wait_drain("single");

        // Fairness: all four at once, then ch3 before ch1 after a ch1 grant
        do_reset();
        setup();
        out_ready = 1'b1;
        for (int ch = 0; ch < N; ch++)
            set_word(ch, W'(32'h10000 + ch), T'(32'h000200 + ch), 1'b1);
        tick();
        clear_pulses();
        tick();
        for (int k = 0; k < N; k++) begin
            check("fair_valid", 32'(out_valid), 32'd1);
            check("fair_id",    32'(out_sensor_id), 32'(k));
            tick();
        end
        wait_drain("fair4");
        set_word(1, 17'h00011, 24'h000301, 1'b1);
        tick();
        clear_pulses();
        wait_drain("fair_ch1");
        set_word(3, 17'h00033, 24'h000403, 1'b1);
        set_word(1, 17'h00031, 24'h000401, 1'b1);
        tick();
        clear_pulses();
        tick();
        check("rr_first",  32'(out_sensor_id), 32'd3);
        tick();
        check("rr_second", 32'(out_sensor_id), 32'd1);
        wait_drain("fair_rr");

        // Backpressure and overflow on ch1
        do_reset();
        setup();
        set_word(1, 17'h0AAAA, 24'h00A000, 1'b1);
        tick();
        set_word(1, 17'h0BBBB, 24'h00B000, 1'b1);
        tick();
        set_word(1, 17'h0CCCC, 24'h00C000, 1'b0);
        tick();
        clear_pulses();
        check("ovf_set",    32'(overflow), 32'b0010);
        check("bp_data_a",  32'(out_data), 32'h0AAAA);
        tick();
        tick();
        check("bp_valid",   32'(out_valid), 32'd1);
        check("bp_stable",  32'(out_data), 32'h0AAAA);
        check("bp_ts",      32'(out_timestamp), 32'h00A000);
        check("ovf_sticky", 32'(overflow), 32'b0010);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_clear",  32'(overflow), 32'd0);
        wait_drain("ovf");

        // Pop and capture on the same channel in the same cycle
        do_reset();
        setup();
        set_word(0, 17'h00F00, 24'h000F00, 1'b1);
        tick();
        set_word(0, 17'h0A0A0, 24'h000A0A, 1'b1);
        tick();
        clear_pulses();
        tick();
        set_word(0, 17'h0B0B0, 24'h000B0B, 1'b1);
        out_ready = 1'b1;
        tick();
        clear_pulses();
        check("popcap_ovf",  32'(overflow), 32'd0);
        check("popcap_data", 32'(out_data), 32'h0A0A0);
        wait_drain("popcap");
        check("popcap_ovf_end", 32'(overflow), 32'd0);

        // Masking a pending channel
        do_reset();
        setup();
        set_word(0, 17'h01234, 24'h001234, 1'b1);
        set_word(3, 17'h03333, 24'h003333, 1'b0);
        tick();
        clear_pulses();
        tick();
        channel_mask = 4'b0111;
        check("mask_lag",  32'(decoder_enable), 32'hF);
        tick();
        check("mask_dec",  32'(decoder_enable), 32'b0111);
        set_word(3, 17'h03334, 24'h003334, 1'b0);
        tick();
        clear_pulses();
        wait_drain("mask");
        for (int k = 0; k < 5; k++) tick();
        check("mask_quiet", 32'(out_valid), 32'd0);

        // Reset in the middle of a stream
        do_reset();
        setup();
        set_word(0, 17'h00E00, 24'h000E00, 1'b0);
        set_word(1, 17'h00E01, 24'h000E01, 1'b0);
        set_word(2, 17'h00E02, 24'h000E02, 1'b0);
        tick();
        clear_pulses();
        tick();
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_valid",  32'(out_valid),      32'd0);
        check("mid_data",   32'(out_data),       32'd0);
        check("mid_ts",     32'(out_timestamp),  32'd0);
        check("mid_id",     32'(out_sensor_id),  32'd0);
        check("mid_ovf",    32'(overflow),       32'd0);
        check("mid_dec_en", 32'(decoder_enable), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        check("mid_no_stale", 32'(out_valid), 32'd0);
        check("mid_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
